// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register.
// Captures the execute-stage result, store data and destination/control bits
// for the memory stage. Supports stall (hold), flush (bubble), alignment
// checking of memory accesses and a sticky halt flag. Outputs are registered.

module ex_mem_reg #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_store_data,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic               i_mem_to_reg,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    input  logic               i_halt,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic [1:0]         o_size,
    output logic               o_unsigned,
    output logic               o_misaligned,
    output logic               o_halt
);

    // Alignment rule: bytes are always aligned, halves need addr[0]=0,
    // words (and the reserved size 11) need addr[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    // Pipeline register state
    logic               valid_r,      valid_s;
    logic [NB_DATA-1:0] alu_result_r, alu_result_s;
    logic [NB_DATA-1:0] store_data_r, store_data_s;
    logic [NB_REG-1:0]  write_reg_r,  write_reg_s;
    logic               reg_write_r,  reg_write_s;
    logic               mem_read_r,   mem_read_s;
    logic               mem_write_r,  mem_write_s;
    logic               mem_to_reg_r, mem_to_reg_s;
    logic [1:0]         size_r,       size_s;
    logic               unsigned_r,   unsigned_s;
    logic               misaligned_r, misaligned_s;
    logic               halt_r,       halt_s;

    // Decode of the incoming instruction
    logic access_s;
    logic in_misaligned_s;
    logic in_halt_s;
    logic block_s;

    // Next-state selection: flush > stall > halted > load (reset is applied in the register)
    always_comb begin
        access_s        = i_valid & (i_mem_read | i_mem_write);
        in_misaligned_s = access_s & is_misaligned(i_size, i_alu_result[1:0]);
        in_halt_s       = i_valid & i_halt;
        // A misaligned access or a halt entry must not touch memory or the register file
        block_s         = in_misaligned_s | in_halt_s;

        valid_s      = valid_r;
        alu_result_s = alu_result_r;
        store_data_s = store_data_r;
        write_reg_s  = write_reg_r;
        reg_write_s  = reg_write_r;
        mem_read_s   = mem_read_r;
        mem_write_s  = mem_write_r;
        mem_to_reg_s = mem_to_reg_r;
        size_s       = size_r;
        unsigned_s   = unsigned_r;
        misaligned_s = misaligned_r;
        halt_s       = halt_r;

        if (i_flush || (!i_stall && halt_r)) begin
            // Bubble: no valid entry, no side effects, data cleared, halt kept
            valid_s      = 1'b0;
            alu_result_s = {NB_DATA{1'b0}};
            store_data_s = {NB_DATA{1'b0}};
            write_reg_s  = {NB_REG{1'b0}};
            reg_write_s  = 1'b0;
            mem_read_s   = 1'b0;
            mem_write_s  = 1'b0;
            mem_to_reg_s = 1'b0;
            size_s       = 2'b00;
            unsigned_s   = 1'b0;
            misaligned_s = 1'b0;
            halt_s       = halt_r;
        end else if (i_stall) begin
            // Hold: keep the current entry (defaults already hold everything)
            valid_s      = valid_r;
            halt_s       = halt_r;
        end else begin
            // Load: capture the EX-stage instruction, gating controls by validity
            valid_s      = i_valid;
            alu_result_s = i_alu_result;
            store_data_s = i_store_data;
            write_reg_s  = i_write_reg;
            reg_write_s  = i_valid & i_reg_write & ~block_s;
            mem_read_s   = i_valid & i_mem_read  & ~block_s;
            mem_write_s  = i_valid & i_mem_write & ~block_s;
            mem_to_reg_s = i_valid & i_mem_to_reg & ~in_halt_s;
            size_s       = i_size;
            unsigned_s   = i_unsigned;
            misaligned_s = in_misaligned_s & ~in_halt_s;
            halt_s       = in_halt_s;
        end
    end

    // Register update with synchronous active-high reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_r      <= 1'b0;
            alu_result_r <= {NB_DATA{1'b0}};
            store_data_r <= {NB_DATA{1'b0}};
            write_reg_r  <= {NB_REG{1'b0}};
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            misaligned_r <= 1'b0;
            halt_r       <= 1'b0;
        end else begin
            valid_r      <= valid_s;
            alu_result_r <= alu_result_s;
            store_data_r <= store_data_s;
            write_reg_r  <= write_reg_s;
            reg_write_r  <= reg_write_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            mem_to_reg_r <= mem_to_reg_s;
            size_r       <= size_s;
            unsigned_r   <= unsigned_s;
            misaligned_r <= misaligned_s;
            halt_r       <= halt_s;
        end
    end

    assign o_valid      = valid_r;
    assign o_alu_result = alu_result_r;
    assign o_store_data = store_data_r;
    assign o_write_reg  = write_reg_r;
    assign o_reg_write  = reg_write_r;
    assign o_mem_read   = mem_read_r;
    assign o_mem_write  = mem_write_r;
    assign o_mem_to_reg = mem_to_reg_r;
    assign o_size       = size_r;
    assign o_unsigned   = unsigned_r;
    assign o_misaligned = misaligned_r;
    assign o_halt       = halt_r;

endmodule
